// File: rtl/serial_frame_receiver_if.sv
// rtl/serial_frame_receiver_if.sv - output word handshake between the frame receiver and its consumer
interface serial_frame_receiver_if #(
  parameter int DATA_WIDTH = 40
);
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/serial_frame_receiver.sv
// rtl/serial_frame_receiver.sv - LSB-first serial frame deserializer with a one-entry output buffer
module serial_frame_receiver #(
  parameter int DATA_WIDTH = 40,
  parameter int IDLE_GAP   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sin,
  input  logic                     err_clr,
  output logic                     busy,
  output logic                     overrun,
  output logic                     frame_err,
  serial_frame_receiver_if.master  out_if
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int GW = $clog2(IDLE_GAP + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]            state_q,     state_d;
  logic [DATA_WIDTH-2:0] shift_q,     shift_d;
  logic [CW-1:0]         cnt_q,       cnt_d;
  logic [GW-1:0]         gap_q,       gap_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  overrun_q,   overrun_d;
  logic                  frame_err_q, frame_err_d;

  logic                  complete;
  logic [DATA_WIDTH-1:0] word;
  logic [GW-1:0]         gap_inc;

  // The final data bit is never stored in the shift register; it joins the word directly.
  assign word    = {sin, shift_q};
  assign gap_inc = gap_q + GW'(1);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    complete    = 1'b0;

    if (err_clr) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end

    if (out_valid_q && out_if.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (sin) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        shift_d             = shift_q >> 1;
        shift_d[DATA_WIDTH-2] = sin;
        cnt_d               = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          complete = 1'b1;
          cnt_d    = '0;
          gap_d    = '0;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        if (sin) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          gap_d = gap_inc;
          if (gap_inc == GW'(IDLE_GAP)) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A consume on the completion edge frees the buffer for the new word.
    if (complete) begin
      if (!out_valid_q || out_if.out_ready) begin
        out_data_d  = word;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;
  assign busy             = (state_q == S_SHIFT) || (state_q == S_GAP);
  assign overrun          = overrun_q;
  assign frame_err        = frame_err_q;
endmodule
